// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives the imem req/ack port,
// and holds a one-entry IF/ID slot with stall and redirect handling.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
  output logic [31:0] pc_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_q, drain_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;

  logic can_issue;
  logic req;
  logic ack;
  logic capture;

  assign can_issue = !valid_q || !stall_i;

  always_comb begin
    req = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE:    req = can_issue;
        BUSY:    req = 1'b1;
        DRAIN:   req = 1'b1;
        default: req = 1'b0;
      endcase
    end
  end

  assign ack     = req && imem_ack_i;
  assign capture = ack && (state_q != DRAIN) && !redirect_i;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drain_d = drain_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    if (redirect_i) begin
      // Redirect wins; an in-flight fetch becomes a drain.
      valid_d = 1'b0;
      pc_d    = redirect_pc_i & ~32'h3;
      unique case (state_q)
        IDLE: begin
          if (req && !ack) begin
            drain_d = pc_q;
            state_d = DRAIN;
          end
        end
        BUSY: begin
          if (ack) begin
            state_d = IDLE;
          end else begin
            drain_d = pc_q;
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      if (capture) begin
        instr_d = imem_rdata_i;
        ipc_d   = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd4;
      end else if (valid_q && !stall_i) begin
        valid_d = 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (req && !ack) state_d = BUSY;
        end
        BUSY: begin
          if (ack) state_d = IDLE;
        end
        DRAIN: begin
          if (ack) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      drain_q <= 32'h0;
      instr_q <= 32'h0;
      ipc_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = (state_q == DRAIN) ? drain_q : pc_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;

endmodule
